// File: rtl/mpsoc_mpram_pkg.sv
// Shared definitions for the banked multi-port AHB3-Lite RAM.
// Contents: AHB3 HTRANS/HSIZE/HRESP encodings and the per-port state encoding.
package mpsoc_mpram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Per-port data-phase state
  typedef logic [2:0] port_state_t;
  localparam port_state_t ST_IDLE    = 3'd0;  // no transfer outstanding
  localparam port_state_t ST_WAIT    = 3'd1;  // pending, requesting its bank
  localparam port_state_t ST_RD_DATA = 3'd2;  // read granted last cycle, data out now
  localparam port_state_t ST_ERR1    = 3'd3;  // first ERROR cycle (HREADYOUT low)
  localparam port_state_t ST_ERR2    = 3'd4;  // second ERROR cycle (HREADYOUT high)

endpackage

// File: rtl/mpsoc_mpram_rr_arbiter.sv
// Round-robin arbiter for one memory bank.
// Ports: clk, rst (sync, active-high), req[N] requests, gnt[N] one-hot grant.
// The search starts at the internal pointer; after a grant the pointer moves
// to grantee+1 (wrapping), so the grantee becomes lowest priority next time.
module mpsoc_mpram_rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;

  always_comb begin
    int unsigned idx;
    idx   = 0;
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = PW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_mpram_banked.sv
// Multi-port AHB3-Lite RAM with word-interleaved banks.
// Ports (per slave port p < CORES_PER_TILE):
//   HCLK, HRESET (sync, active-high)
//   HSEL, HADDR, HWDATA, HWRITE, HSIZE, HTRANS, HREADY : AHB3 slave inputs
//   HBURST, HPROT, HMASTLOCK                          : accepted, unused
//   HRDATA, HREADYOUT, HRESP                          : AHB3 slave outputs
// Bank = word address mod BANKS, row = word address / BANKS. Each bank has a
// round-robin arbiter; losers see HREADYOUT low until granted. Writes are
// performed in the grant cycle; reads sample the bank at the grant edge and
// present data in the following cycle. Assumes BANKS >= 2 and >= 2 rows/bank.
module mpsoc_ahb3_mpram_banked
  import mpsoc_mpram_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned PLEN           = 64,
  parameter int unsigned CORES_PER_TILE = 8,
  parameter int unsigned MEM_SIZE       = 1024,
  parameter int unsigned BANKS          = 4
) (
  input  logic                                      HCLK,
  input  logic                                      HRESET,
  input  logic [CORES_PER_TILE-1:0]                 HSEL,
  input  logic [CORES_PER_TILE-1:0][PLEN-1:0]       HADDR,
  input  logic [CORES_PER_TILE-1:0][XLEN-1:0]       HWDATA,
  output logic [CORES_PER_TILE-1:0][XLEN-1:0]       HRDATA,
  input  logic [CORES_PER_TILE-1:0]                 HWRITE,
  input  logic [CORES_PER_TILE-1:0][2:0]            HSIZE,
  input  logic [CORES_PER_TILE-1:0][2:0]            HBURST,
  input  logic [CORES_PER_TILE-1:0][3:0]            HPROT,
  input  logic [CORES_PER_TILE-1:0][1:0]            HTRANS,
  input  logic [CORES_PER_TILE-1:0]                 HMASTLOCK,
  input  logic [CORES_PER_TILE-1:0]                 HREADY,
  output logic [CORES_PER_TILE-1:0]                 HREADYOUT,
  output logic [CORES_PER_TILE-1:0]                 HRESP
);

  localparam int unsigned NP   = CORES_PER_TILE;
  localparam int unsigned WB   = XLEN / 8;
  localparam int unsigned SZ   = $clog2(WB);
  localparam int unsigned AW   = $clog2(MEM_SIZE);
  localparam int unsigned BB   = $clog2(BANKS);
  localparam int unsigned ROWS = MEM_SIZE / WB / BANKS;
  localparam int unsigned RB   = $clog2(ROWS);

  // Lanes covered by a naturally aligned transfer; low offset bits below the
  // transfer size are dropped so a misaligned address selects its aligned lanes.
  function automatic logic [WB-1:0] calc_be(input logic [2:0] size, input logic [SZ-1:0] off);
    int unsigned lanes;
    int unsigned base;
    lanes   = 32'd1 << size;
    base    = 32'(off) & ~(lanes - 32'd1);
    calc_be = '0;
    for (int unsigned i = 0; i < WB; i++) calc_be[i] = (i >= base) && (i < base + lanes);
  endfunction

  port_state_t       state_q [NP];
  logic              write_q [NP];
  logic [BB-1:0]     bank_q  [NP];
  logic [RB-1:0]     row_q   [NP];
  logic [WB-1:0]     be_q    [NP];
  logic [XLEN-1:0]   rdata_q [NP];

  logic [NP-1:0]     accept;
  logic [NP-1:0]     bad;
  logic [NP-1:0]     pgnt;
  logic [NP-1:0]     req [BANKS];
  logic [NP-1:0]     gnt [BANKS];
  logic [XLEN-1:0]   bank_rdata [BANKS];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS};

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      accept[p] = HSEL[p] & HREADY[p] & HTRANS[p][1];
      bad[p]    = (HADDR[p][PLEN-1:AW] != '0) || (HSIZE[p] > 3'(SZ));
    end
  end

  // Requests are masked during reset so nothing granted in that cycle touches memory.
  always_comb begin
    for (int unsigned b = 0; b < BANKS; b++) begin
      for (int unsigned p = 0; p < NP; p++) begin
        req[b][p] = !HRESET && (state_q[p] == ST_WAIT) && (bank_q[p] == BB'(b));
      end
    end
  end

  always_comb begin
    pgnt = '0;
    for (int unsigned p = 0; p < NP; p++) pgnt[p] = gnt[bank_q[p]][p];
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [XLEN-1:0] mem [ROWS];
    logic [XLEN-1:0] rd_q;
    logic            sel_wr;
    logic            sel_rd;
    logic [RB-1:0]   sel_row;
    logic [WB-1:0]   sel_be;
    logic [XLEN-1:0] sel_wdata;

    mpsoc_mpram_rr_arbiter #(.N(NP)) u_arb (
      .clk (HCLK),
      .rst (HRESET),
      .req (req[b]),
      .gnt (gnt[b])
    );

    always_comb begin
      sel_wr    = 1'b0;
      sel_rd    = 1'b0;
      sel_row   = '0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int unsigned p = 0; p < NP; p++) begin
        if (gnt[b][p]) begin
          sel_wr    = write_q[p];
          sel_rd    = !write_q[p];
          sel_row   = row_q[p];
          sel_be    = be_q[p];
          sel_wdata = HWDATA[p];
        end
      end
    end

    always_ff @(posedge HCLK) begin
      if (sel_wr) begin
        for (int unsigned i = 0; i < WB; i++) begin
          if (sel_be[i]) mem[sel_row][8*i +: 8] <= sel_wdata[8*i +: 8];
        end
      end
      if (sel_rd) rd_q <= mem[sel_row];
    end

    assign bank_rdata[b] = rd_q;
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      case (state_q[p])
        ST_WAIT: HREADYOUT[p] = write_q[p] & pgnt[p];
        ST_ERR1: HREADYOUT[p] = 1'b0;
        default: HREADYOUT[p] = 1'b1;
      endcase
      HRESP[p]  = (state_q[p] == ST_ERR1 || state_q[p] == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      HRDATA[p] = (state_q[p] == ST_RD_DATA) ? bank_rdata[bank_q[p]] : rdata_q[p];
    end
  end

  // A new address phase is only taken in states where HREADYOUT is high this cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int unsigned p = 0; p < NP; p++) begin
        state_q[p] <= ST_IDLE;
        write_q[p] <= 1'b0;
        bank_q[p]  <= '0;
        row_q[p]   <= '0;
        be_q[p]    <= '0;
        rdata_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (state_q[p] == ST_RD_DATA) rdata_q[p] <= bank_rdata[bank_q[p]];
        if (state_q[p] == ST_ERR1) begin
          state_q[p] <= ST_ERR2;
        end else if (state_q[p] == ST_WAIT && !pgnt[p]) begin
          state_q[p] <= ST_WAIT;
        end else if (state_q[p] == ST_WAIT && !write_q[p]) begin
          state_q[p] <= ST_RD_DATA;
        end else if (accept[p]) begin
          if (bad[p]) begin
            state_q[p] <= ST_ERR1;
          end else begin
            state_q[p] <= ST_WAIT;
            write_q[p] <= HWRITE[p];
            bank_q[p]  <= HADDR[p][SZ+BB-1:SZ];
            row_q[p]   <= HADDR[p][AW-1:SZ+BB];
            be_q[p]    <= calc_be(HSIZE[p], HADDR[p][SZ-1:0]);
          end
        end else begin
          state_q[p] <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpsoc_ahb3_mpram_banked.sv
// Self-checking bench for mpsoc_ahb3_mpram_banked (XLEN=32, 4 ports, 4 banks,
// 1 KiB). A byte-array memory plus per-bank round-robin pointers predict data,
// completion cycle and response of every transfer in a batch of simultaneous
// single-beat transfers issued on the ports.
module tb_mpsoc_ahb3_mpram_banked;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PLEN  = 32;
  localparam int unsigned NP    = 4;
  localparam int unsigned MEM   = 1024;
  localparam int unsigned BANKS = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]            hsel, hwrite, hready, hreadyout, hresp, hmastlock;
  logic [NP-1:0][PLEN-1:0]  haddr;
  logic [NP-1:0][XLEN-1:0]  hwdata, hrdata;
  logic [NP-1:0][2:0]       hsize, hburst;
  logic [NP-1:0][3:0]       hprot;
  logic [NP-1:0][1:0]       htrans;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  mpsoc_ahb3_mpram_banked #(
    .XLEN(XLEN), .PLEN(PLEN), .CORES_PER_TILE(NP), .MEM_SIZE(MEM), .BANKS(BANKS)
  ) dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mref [MEM];
  int         rr [BANKS];

  logic        b_act [NP];
  logic        b_wr  [NP];
  logic [31:0] b_addr[NP];
  logic [31:0] b_wdata[NP];
  logic [2:0]  b_size[NP];
  int          last_done [NP];
  logic [31:0] last_rdata[NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_err(input logic [31:0] addr, input logic [2:0] size);
    return (addr >= MEM) || (size > 3'd2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned a;
    a = addr & ~32'd3;
    return {mref[a+3], mref[a+2], mref[a+1], mref[a]};
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [31:0] data);
    int unsigned a, n, base;
    a    = addr & ~32'd3;
    n    = 32'd1 << size;
    base = (addr & 32'd3) & ~(n - 1);
    for (int unsigned i = base; i < base + n; i++) mref[a+i] = data[8*i +: 8];
  endfunction

  task automatic clear_batch();
    for (int p = 0; p < NP; p++) begin
      b_act[p] = 1'b0; b_wr[p] = 1'b0; b_addr[p] = '0; b_wdata[p] = '0; b_size[p] = 3'd2;
    end
  endtask

  task automatic set_op(input int p, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] data);
    b_act[p] = 1'b1; b_wr[p] = wr; b_addr[p] = addr; b_size[p] = size; b_wdata[p] = data;
  endtask

  task automatic rand_op(input int p);
    logic [31:0] addr;
    logic [2:0]  size;
    addr = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 255) : $urandom_range(0, MEM - 1);
    size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    set_op(p, 1'($urandom_range(0, 1)), addr, size, $urandom);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic run_batch(input string tag);
    int          exp_done [NP];
    logic        exp_err  [NP];
    logic [31:0] exp_rdata[NP];
    int          done     [NP];
    logic        rdy1[NP], resp1[NP], resp_d[NP];
    logic [31:0] rdata_d[NP];
    logic        all_done;
    int          rank, last, p;

    for (int q = 0; q < NP; q++) begin
      exp_err[q]   = b_act[q] && is_err(b_addr[q], b_size[q]);
      exp_done[q]  = exp_err[q] ? 2 : 0;
      exp_rdata[q] = '0;
      done[q] = 0; rdy1[q] = 1'b0; resp1[q] = 1'b0; resp_d[q] = 1'b0; rdata_d[q] = '0;
    end
    for (int b = 0; b < BANKS; b++) begin
      rank = 0;
      last = -1;
      for (int k = 0; k < NP; k++) begin
        p = (rr[b] + k) % NP;
        if (b_act[p] && !exp_err[p] && int'((b_addr[p] >> 2) % BANKS) == b) begin
          rank++;
          last = p;
          if (b_wr[p]) begin
            model_write(b_addr[p], b_size[p], b_wdata[p]);
            exp_done[p] = rank;
          end else begin
            exp_rdata[p] = model_read(b_addr[p]);
            exp_done[p]  = rank + 1;
          end
        end
      end
      if (last >= 0) rr[b] = (last + 1) % NP;
    end

    for (int q = 0; q < NP; q++) begin
      hsel[q]   = b_act[q];
      htrans[q] = b_act[q] ? 2'b10 : 2'b00;
      haddr[q]  = b_addr[q];
      hwrite[q] = b_wr[q];
      hsize[q]  = b_size[q];
    end
    @(posedge clk); #1;
    hsel   = '0;
    htrans = '0;
    for (int q = 0; q < NP; q++) hwdata[q] = b_wr[q] ? b_wdata[q] : '0;

    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      all_done = 1'b1;
      for (int q = 0; q < NP; q++) begin
        if (b_act[q] && done[q] == 0) begin
          if (c == 1) begin rdy1[q] = hreadyout[q]; resp1[q] = hresp[q]; end
          if (hreadyout[q]) begin
            done[q] = c; resp_d[q] = hresp[q]; rdata_d[q] = hrdata[q];
          end else begin
            all_done = 1'b0;
          end
        end
      end
      @(posedge clk); #1;
      if (all_done) break;
    end

    for (int q = 0; q < NP; q++) begin
      last_done[q]  = done[q];
      last_rdata[q] = rdata_d[q];
      if (b_act[q]) begin
        check($sformatf("%s p%0d cycles", tag, q), 64'(done[q]), 64'(exp_done[q]));
        check($sformatf("%s p%0d ready1", tag, q), 64'(rdy1[q]), 64'(exp_done[q] == 1));
        check($sformatf("%s p%0d resp1", tag, q), 64'(resp1[q]), 64'(exp_err[q]));
        check($sformatf("%s p%0d resp", tag, q), 64'(resp_d[q]), 64'(exp_err[q]));
        if (!b_wr[q] && !exp_err[q])
          check($sformatf("%s p%0d rdata", tag, q), 64'(rdata_d[q]), 64'(exp_rdata[q]));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hreadyout"}, 64'(hreadyout), 64'hF);
    check({tag, " hresp"}, 64'(hresp), 64'h0);
    for (int q = 0; q < NP; q++) check($sformatf("%s hrdata%0d", tag, q), 64'(hrdata[q]), 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int b = 0; b < BANKS; b++) rr[b] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsel = '0; hwrite = '0; haddr = '0; hwdata = '0; hsize = '0;
    hburst = '0; hprot = '0; htrans = '0; hmastlock = '0;
    for (int b = 0; b < BANKS; b++) rr[b] = 0;
    @(posedge clk); #1;
    do_reset();
    check_reset_outputs("reset");

    // Write then read back on port 0
    clear_batch(); set_op(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF); run_batch("wr10");
    clear_batch(); set_op(0, 1'b0, 32'h10, 3'd2, 32'h0);        run_batch("rd10");
    check("rd10 value", 64'(last_rdata[0]), 64'hDEADBEEF);
    check("rd10 hold", 64'(hrdata[0]), 64'hDEADBEEF);

    // Distinct banks in parallel
    clear_batch();
    for (int q = 0; q < NP; q++) set_op(q, 1'b1, 32'(4 * q), 3'd2, $urandom);
    run_batch("par");
    for (int q = 0; q < NP; q++) check($sformatf("par p%0d one cycle", q), 64'(last_done[q]), 64'd1);

    // All ports on bank 0 from a fresh pointer, then a repeat burst
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      clear_batch();
      for (int q = 0; q < NP; q++) set_op(q, 1'b1, 32'(16 * q), 3'd2, $urandom);
      run_batch($sformatf("cont%0d", rep));
      for (int q = 0; q < NP; q++)
        check($sformatf("cont%0d p%0d order", rep, q), 64'(last_done[q]), 64'(q + 1));
    end

    // Byte lane write
    clear_batch(); set_op(0, 1'b1, 32'h10, 3'd2, 32'h11223344); run_batch("bw_init");
    clear_batch(); set_op(0, 1'b1, 32'h13, 3'd0, 32'hAA000000); run_batch("bw_byte");
    clear_batch(); set_op(0, 1'b0, 32'h10, 3'd2, 32'h0);        run_batch("bw_rd");
    check("bw value", 64'(last_rdata[0]), 64'hAA223344);

    // Error responses leave memory untouched
    clear_batch(); set_op(1, 1'b0, 32'h400, 3'd2, 32'h0);       run_batch("err_addr");
    clear_batch(); set_op(2, 1'b1, 32'h10, 3'd3, 32'h55555555); run_batch("err_size");
    clear_batch(); set_op(3, 1'b0, 32'h10, 3'd2, 32'h0);        run_batch("err_rd");
    check("err mem intact", 64'(last_rdata[3]), 64'hAA223344);

    // Fill the whole memory so random reads have known contents
    for (int w = 0; w < MEM / 4; w += NP) begin
      clear_batch();
      for (int q = 0; q < NP; q++) set_op(q, 1'b1, 32'(4 * (w + q)), 3'd2, $urandom);
      run_batch("fill");
    end

    for (int i = 0; i < 40; i++) begin
      clear_batch();
      rand_op(int'($urandom_range(0, NP - 1)));
      run_batch($sformatf("single%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      clear_batch();
      for (int q = 0; q < NP; q++) if ($urandom_range(0, 3) != 0) rand_op(q);
      run_batch($sformatf("multi%0d", i));
    end

    // Reset while ports wait in bank 0 contention
    do_reset();
    clear_batch();
    for (int q = 0; q < NP; q++) begin
      hsel[q] = 1'b1; htrans[q] = 2'b10; hwrite[q] = 1'b1; hsize[q] = 3'd2;
      haddr[q] = 32'h80 + 32'(16 * q);
    end
    @(posedge clk); #1;
    hsel = '0; htrans = '0;
    for (int q = 0; q < NP; q++) hwdata[q] = $urandom;
    @(negedge clk);
    check("rstmid grant1", 64'(hreadyout), 64'h1);
    model_write(32'h80, 3'd2, hwdata[0]);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hwdata = '0;
    for (int b = 0; b < BANKS; b++) rr[b] = 0;
    check_reset_outputs("rstmid");
    for (int q = 0; q < NP; q++) set_op(q, 1'b0, 32'h80 + 32'(16 * q), 3'd2, 32'h0);
    run_batch("rstmid_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
